ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-master AHB-Lite initiator that sits directly upstream of the pcounter AHB slave wrapper and drives its AHB inputs.
- Accepts simple register requests on a valid/ready interface and buffers them in a request FIFO.
- Issues each request as a pipelined single WORD transfer (NONSEQ/SINGLE/WORD) with overlapped address and data phases.
- Returns one in-order response per request, carrying read data and error status.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of two, >=2).
- HPROT_VAL, 4'b0011, constant driven on hprot.

Ports:
- hclk  in  1  clock; all logic on posedge.
- hreset  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !full && !hreset.
- req_write  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse per completed request.
- rsp_write  out  1  direction of completed request.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_err  out  1  slave returned ERROR.
- haddr  out  32  AHB address.
- hwrite  out  1  AHB direction.
- htrans  out  ahb_htrans_enum  IDLE or NONSEQ only.
- hburst  out  ahb_hburst_enum  constant SINGLE.
- hsize  out  ahb_hsize_enum  constant WORD.
- hprot  out  4  constant HPROT_VAL.
- hsel  out  1  high whenever htrans==NONSEQ.
- hwdata  out  32  write data during data phase.
- hready_in  out  1  tied to the hready input (single-slave system).
- hrdata  in  32  read data.
- hready  in  1  slave ready.
- hresp  in  ahb_hresp_enum  OKAY/ERROR.

Behaviour:
- Reset values (cycle after hreset sampled high):
  - htrans=IDLE, hsel=0, haddr=0, hwrite=0, hwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_write=0.
  - FIFO emptied; all outstanding transfers abandoned with no response.
- Reset mid-transfer is legal; reset overrides every other event.
- Request push: occurs on a posedge with req_valid && req_ready.
  - When the FIFO is full, req_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full; occupancy is then unchanged.
- Pipeline: two registered stages, address phase (AP) and data phase (DP).
- AP load: the FIFO head is popped into AP on a posedge when:
  - the FIFO is non-empty, and
  - AP is empty, or AP is valid and hready=1 (AP advancing), and
  - the cancel state (below) is not active.
- AP outputs: htrans=NONSEQ with haddr/hwrite from AP while AP is valid; otherwise htrans=IDLE.
  - haddr and hwrite hold their last values while IDLE.
- AP to DP: on a posedge with hready=1, AP moves to DP.
  - hwdata is driven from the DP entry's wdata for the whole data phase, held through wait states.
- DP completion: a posedge with DP valid and hready=1.
  - Next cycle: rsp_valid=1, rsp_rdata=hrdata (reads) or 0 (writes), rsp_err=(hresp==ERROR), rsp_write=DP direction.
- Back-to-back transfers: AP of request n+1 overlaps DP of request n; sustained throughput is 1 transfer/cycle at zero wait states.
- Latency, zero wait states, empty pipe:
  - request accepted at edge N;
  - NONSEQ on bus after N+1;
  - data phase after N+2;
  - rsp_valid high for the cycle after N+3.
- Wait states: AP and DP are both frozen while hready=0; no FIFO pop occurs.
- Error (two-cycle response):
  - When DP sees hresp=ERROR with hready=0, enter the cancel state.
  - On the next posedge, drive htrans=IDLE; an AP entry that is pending but not yet accepted is held, not dropped.
  - At the posedge where hready=1 with hresp=ERROR, DP completes with rsp_err=1.
  - The held AP entry is re-issued as NONSEQ the following cycle.
- Responses are strictly in request order; there is no response backpressure.

Optional Feature:
- Macro: AHB_MASTER_ALIGN_CHK_EN.
- Defined:
  - A request with req_addr[1:0]!=0 is not issued on the bus.
  - When it reaches the FIFO head, it is popped into a bypass slot and produces rsp_valid with rsp_err=1 and rsp_rdata=0.
  - The response stays in order behind any in-flight DP completion.
- Not defined: haddr[1:0] is forced to 2'b00 and the transfer proceeds normally.

Test Plan:
- Reset, then a single write addr=0x04, data=0x0000_00A5 with hready=1 → NONSEQ/hwrite=1/haddr=0x04 one cycle after acceptance, hwdata=0xA5 next cycle, rsp_valid with rsp_err=0 three cycles after acceptance.
- Read addr=0x08 with the slave returning 0x1234_5678 → rsp_rdata=0x1234_5678 and rsp_write=0.
- Four back-to-back writes followed by four reads at hready=1 → 8 consecutive NONSEQ cycles with no IDLE gaps, and 8 responses in order.
- Read with hready=0 for 3 data-phase cycles → haddr of the next transfer held, no pop, response delayed by exactly 3 cycles.
- Slave ERROR on a write while a read is queued in AP → htrans=IDLE for one cycle, rsp_err=1, then the read is re-issued and completes OKAY.
- Fill the FIFO (FIFO_DEPTH=4) with hready=0 → req_ready=0 after the 4th push; assert hreset mid-burst → htrans=IDLE next cycle, no rsp_valid, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus types and the request/response + AHB bundle used by ahb_lite_master.
// The master modport is the initiator's view; the slave modport is the far side.
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_htrans_enum;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } ahb_hburst_enum;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } ahb_hsize_enum;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahb_hresp_enum;
endpackage

interface ahb_lite_master_if;
  import ahb_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [31:0]    req_addr;
  logic [31:0]    req_wdata;
  logic           rsp_valid;
  logic           rsp_write;
  logic [31:0]    rsp_rdata;
  logic           rsp_err;
  logic [31:0]    haddr;
  logic           hwrite;
  ahb_htrans_enum htrans;
  ahb_hburst_enum hburst;
  ahb_hsize_enum  hsize;
  logic [3:0]     hprot;
  logic           hsel;
  logic [31:0]    hwdata;
  logic           hready_in;
  logic [31:0]    hrdata;
  logic           hready;
  ahb_hresp_enum  hresp;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, hrdata, hready, hresp,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output haddr, hwrite, htrans, hburst, hsize, hprot, hsel, hwdata, hready_in
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, hrdata, hready, hresp,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  haddr, hwrite, htrans, hburst, hsize, hprot, hsel, hwdata, hready_in
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-master AHB-Lite initiator: request FIFO -> pipelined AP/DP single WORD transfers -> in-order responses.
// Optional macro AHB_MASTER_ALIGN_CHK_EN: misaligned requests are answered with an error instead of being issued.
module ahb_lite_master #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input logic               hclk,
  input logic               hreset,
  ahb_lite_master_if.master bus
);
  import ahb_pkg::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // ST_CANCEL covers the second cycle of a two-cycle ERROR response, where the pending address is withdrawn.
  typedef enum logic {ST_RUN, ST_CANCEL} state_e;

  req_t           r_fifo [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr, r_rd_ptr;
  state_e         r_state, w_state_next;

  logic           r_ap_valid, r_ap_write;
  logic [31:0]    r_ap_addr, r_ap_wdata;
  logic           r_dp_valid, r_dp_write;
  logic [31:0]    r_dp_wdata;
  logic           r_rsp_valid, r_rsp_write, r_rsp_err;
  logic [31:0]    r_rsp_rdata;

  logic           w_full, w_empty, w_req_ready, w_push, w_pop;
  logic           w_pop_bus, w_pop_byp, w_head_misaligned;
  logic           w_ap_adv, w_dp_done, w_running;
  req_t           w_head, w_push_req;
  ahb_htrans_enum w_htrans;

  assign w_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_req_ready = !w_full && !hreset;
  assign w_push      = bus.req_valid && w_req_ready;
  assign w_head      = r_fifo[r_rd_ptr[PTR_W-1:0]];
  assign w_running   = (r_state == ST_RUN);

`ifdef AHB_MASTER_ALIGN_CHK_EN
  assign w_push_req        = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
  assign w_head_misaligned = (w_head.addr[1:0] != 2'b00);
  // Waiting for an empty pipe keeps the error response behind every older transfer.
  assign w_pop_byp         = !w_empty && w_head_misaligned && !r_ap_valid && !r_dp_valid;
`else
  assign w_push_req        = '{write: bus.req_write, addr: {bus.req_addr[31:2], 2'b00},
                               wdata: bus.req_wdata};
  assign w_head_misaligned = 1'b0;
  assign w_pop_byp         = 1'b0;
`endif

  // With hready high and no cancel pending, AP is either empty or advancing, so it can always take the head.
  assign w_ap_adv  = r_ap_valid && bus.hready && w_running;
  assign w_pop_bus = !w_empty && !w_head_misaligned && bus.hready && w_running;
  assign w_pop     = w_pop_bus || w_pop_byp;
  assign w_dp_done = r_dp_valid && bus.hready;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding (a latch).
  always_comb begin
    w_state_next = r_state;
    w_htrans     = HTRANS_IDLE;
    case (r_state)
      ST_RUN: begin
        if (r_ap_valid) w_htrans = HTRANS_NONSEQ;
        if (r_dp_valid && !bus.hready && (bus.hresp == HRESP_ERROR)) w_state_next = ST_CANCEL;
      end
      ST_CANCEL: if (bus.hready) w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // NOTE: the storage array has no reset; only the pointers decide which entries are live.
  always_ff @(posedge hclk) begin
    if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_push_req;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ap_valid  <= 1'b0;
      r_ap_write  <= 1'b0;
      r_ap_addr   <= '0;
      r_ap_wdata  <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{PTR_W{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{PTR_W{1'b0}}, 1'b1};

      if (w_pop_bus) begin
        r_ap_valid <= 1'b1;
        r_ap_write <= w_head.write;
        r_ap_addr  <= w_head.addr;
        r_ap_wdata <= w_head.wdata;
      end else if (w_ap_adv) begin
        r_ap_valid <= 1'b0;
      end

      // A cancelled address phase was never accepted, so nothing enters DP behind the error.
      if (bus.hready) begin
        r_dp_valid <= w_ap_adv;
        if (w_ap_adv) begin
          r_dp_write <= r_ap_write;
          r_dp_wdata <= r_ap_wdata;
        end
      end

      r_rsp_valid <= w_dp_done || w_pop_byp;
      if (w_dp_done) begin
        r_rsp_write <= r_dp_write;
        r_rsp_rdata <= r_dp_write ? 32'h0 : bus.hrdata;
        r_rsp_err   <= (bus.hresp == HRESP_ERROR);
      end else if (w_pop_byp) begin
        r_rsp_write <= w_head.write;
        r_rsp_rdata <= 32'h0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.htrans    = w_htrans;
  assign bus.hsel      = (w_htrans == HTRANS_NONSEQ);
  assign bus.haddr     = r_ap_addr;
  assign bus.hwrite    = r_ap_write;
  assign bus.hwdata    = r_dp_wdata;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hsize     = HSIZE_WORD;
  assign bus.hprot     = HPROT_VAL;
  assign bus.hready_in = bus.hready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: scoreboarded slave model and response monitor plus inline timing checks.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  logic hclk   = 1'b0;
  logic hreset = 1'b1;
  logic mon_en = 1'b0;
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   ns_count = 0, ns_first = 0, ns_last = 0;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  logic        s_dp_valid = 1'b0, s_dp_write = 1'b0;
  logic [31:0] s_dp_addr  = '0,   s_dp_wdata = '0;
  logic        n_valid    = 1'b0, n_write    = 1'b0;
  logic [31:0] n_addr     = '0,   n_wdata    = '0;

  ahb_lite_master_if bus ();

  ahb_lite_master #(.FIFO_DEPTH(4), .HPROT_VAL(4'b0011)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err);
    logic     skip_bus;
    bus_exp_t be;
    rsp_exp_t re;
    int       n;
    skip_bus = 1'b0;
`ifdef AHB_MASTER_ALIGN_CHK_EN
    skip_bus = (addr[1:0] != 2'b00);
`endif
    be.write = wr;
    be.addr  = {addr[31:2], 2'b00};
    be.wdata = wdata;
    if (!skip_bus) bus_q.push_back(be);
    re.write = wr;
    re.rdata = (wr || skip_bus) ? 32'h0 : slave_data(be.addr);
    re.err   = exp_err || skip_bus;
    rsp_q.push_back(re);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_rsp_q", rsp_q.size(), 0);
  endtask

  // Slave model: accepts address phases, checks them against the expected bus queue, serves read data.
  assign bus.hrdata = (s_dp_valid && !s_dp_write) ? slave_data(s_dp_addr) : 32'hDEAD_BEEF;

  always @(negedge hclk) begin
    bus_exp_t e;
    n_valid = s_dp_valid && !bus.hready;
    n_write = s_dp_write;
    n_addr  = s_dp_addr;
    n_wdata = s_dp_wdata;
    if (mon_en && !hreset) begin
      if (s_dp_valid && bus.hready && s_dp_write) check("hwdata", bus.hwdata, s_dp_wdata);
      if (bus.htrans === HTRANS_NONSEQ && bus.hready === 1'b1) begin
        ns_count++;
        if (ns_count == 1) ns_first = cyc;
        ns_last = cyc;
        if (bus_q.size() == 0) begin
          check("bus_unexpected_nonseq", bus.haddr, 32'hFFFF_FFFF);
        end else begin
          e = bus_q.pop_front();
          check("haddr", bus.haddr, e.addr);
          check("hwrite", bus.hwrite, e.write);
          check("hsel_nonseq", bus.hsel, 1'b1);
          n_valid = 1'b1;
          n_write = e.write;
          n_addr  = e.addr;
          n_wdata = e.wdata;
        end
      end
    end else begin
      n_valid = 1'b0;
    end
  end

  always @(posedge hclk) begin
    s_dp_valid <= n_valid;
    s_dp_write <= n_write;
    s_dp_addr  <= n_addr;
    s_dp_wdata <= n_wdata;
  end

  // Response scoreboard.
  always @(negedge hclk) begin
    rsp_exp_t e;
    if (mon_en && bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", bus.rsp_valid, 1'b0);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_write", bus.rsp_write, e.write);
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", bus.rsp_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.hready    = 1'b1;
    bus.hresp     = HRESP_OKAY;
    hreset        = 1'b1;
    tick();
    tick();

    // Reset state while hreset is still high
    @(negedge hclk);
    check("rst_htrans", bus.htrans, HTRANS_IDLE);
    check("rst_hsel", bus.hsel, 1'b0);
    check("rst_haddr", bus.haddr, 32'h0);
    check("rst_hwrite", bus.hwrite, 1'b0);
    check("rst_hwdata", bus.hwdata, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_write", bus.rsp_write, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("hburst", bus.hburst, HBURST_SINGLE);
    check("hsize", bus.hsize, HSIZE_WORD);
    check("hprot", bus.hprot, 4'b0011);
    tick();
    hreset = 1'b0;
    mon_en = 1'b1;
    @(negedge hclk);
    check("req_ready_after_rst", bus.req_ready, 1'b1);
    tick();

    // Single write: latency through AP, DP and response
    push(1'b1, 32'h0000_0004, 32'h0000_00A5, 1'b0);
    @(negedge hclk);
    check("t1_idle_before_ap", bus.htrans, HTRANS_IDLE);
    tick();
    @(negedge hclk);
    check("t1_nonseq", bus.htrans, HTRANS_NONSEQ);
    check("t1_hwrite", bus.hwrite, 1'b1);
    check("t1_haddr", bus.haddr, 32'h0000_0004);
    tick();
    @(negedge hclk);
    check("t1_hwdata", bus.hwdata, 32'h0000_00A5);
    check("t1_no_rsp_yet", bus.rsp_valid, 1'b0);
    tick();
    @(negedge hclk);
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check("t1_rsp_err", bus.rsp_err, 1'b0);
    tick();

    // Single read
    push(1'b0, 32'h0000_0008, 32'h0, 1'b0);
    drain();

    // Four writes then four reads back to back
    ns_count = 0;
    for (int i = 0; i < 4; i++) push(1'b1, 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 32'h100 + 32'(4 * i), 32'h0, 1'b0);
    drain();
    check("b2b_nonseq_count", ns_count, 8);
    check("b2b_nonseq_span", ns_last - ns_first + 1, 8);

    // Read with three wait states; the next address is held on the bus
    push(1'b0, 32'h0000_0020, 32'h0, 1'b0);
    push(1'b0, 32'h0000_0024, 32'h0, 1'b0);
    tick();
    bus.hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      check("ws_haddr_held", bus.haddr, 32'h0000_0024);
      check("ws_htrans", bus.htrans, HTRANS_NONSEQ);
      check("ws_no_rsp", bus.rsp_valid, 1'b0);
      check("ws_hready_in", bus.hready_in, 1'b0);
      tick();
    end
    bus.hready = 1'b1;
    @(negedge hclk);
    check("ws_rsp_not_early", bus.rsp_valid, 1'b0);
    tick();
    @(negedge hclk);
    check("ws_rsp_delayed", bus.rsp_valid, 1'b1);
    drain();

    // Two-cycle ERROR on a write with a read pending in AP
    push(1'b1, 32'h0000_0010, 32'h0000_CAFE, 1'b1);
    push(1'b0, 32'h0000_0014, 32'h0, 1'b0);
    tick();
    bus.hready = 1'b0;
    bus.hresp  = HRESP_ERROR;
    @(negedge hclk);
    check("err1_htrans", bus.htrans, HTRANS_NONSEQ);
    tick();
    bus.hready = 1'b1;
    @(negedge hclk);
    check("err2_htrans_idle", bus.htrans, HTRANS_IDLE);
    check("err2_hsel", bus.hsel, 1'b0);
    check("err2_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    bus.hresp = HRESP_OKAY;
    @(negedge hclk);
    check("err_reissue_htrans", bus.htrans, HTRANS_NONSEQ);
    check("err_reissue_haddr", bus.haddr, 32'h0000_0014);
    check("err_rsp_valid", bus.rsp_valid, 1'b1);
    check("err_rsp_err", bus.rsp_err, 1'b1);
    drain();

    // Misaligned request
    push(1'b0, 32'h0000_002A, 32'h0, 1'b0);
    drain();

    // Fill the FIFO with the slave stalled, then reset mid-burst
    bus.hready = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b1, 32'h200 + 32'(4 * i), 32'(i), 1'b0);
    @(negedge hclk);
    check("fill3_req_ready", bus.req_ready, 1'b1);
    push(1'b1, 32'h0000_020C, 32'h3, 1'b0);
    @(negedge hclk);
    check("full_req_ready", bus.req_ready, 1'b0);
    check("full_htrans", bus.htrans, HTRANS_IDLE);
    tick();
    bus.hready = 1'b1;
    tick();
    @(negedge hclk);
    check("burst_active", bus.htrans, HTRANS_NONSEQ);
    tick();
    hreset = 1'b1;
    bus_q.delete();
    rsp_q.delete();
    @(negedge hclk);
    check("in_rst_req_ready", bus.req_ready, 1'b0);
    tick();
    @(negedge hclk);
    check("midrst_htrans", bus.htrans, HTRANS_IDLE);
    check("midrst_hsel", bus.hsel, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    hreset = 1'b0;
    @(negedge hclk);
    check("post_rst_req_ready", bus.req_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge hclk);
      check("post_rst_no_rsp", bus.rsp_valid, 1'b0);
      check("post_rst_idle", bus.htrans, HTRANS_IDLE);
    end
    tick();

    // Recovery after reset
    push(1'b1, 32'h0000_0040, 32'h0000_0055, 1'b0);
    push(1'b0, 32'h0000_0044, 32'h0, 1'b0);
    drain();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
